// File: rtl/alpha_seq_ctrl.sv
// alpha_seq_ctrl: sequencing controller for the alpha (forward) state-metric
// recursion. A frame handshake is followed by one INIT cycle that loads the
// external initial metrics, then FRAME_LEN recursion steps of STEP_CYC cycles
// each; the last cycle of every step writes the metrics to memory at the step
// index. DONE holds until the downstream acknowledges.
//
// Optional feature macro: ALPHA_SEQ_STALL_EN
//   When defined, RUN cycles advance only while gamma_valid=1; acs_en and
//   wr_en are then gated by gamma_valid in the same cycle. When undefined,
//   gamma_valid is ignored and every outcome is a registered output.
module alpha_seq_ctrl #(
    parameter int N         = 12,
    parameter int FRAME_LEN = 14,
    parameter int ADDR_W    = 4,
    parameter int STEP_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frm_valid,
    output logic              frm_ready,
    input  logic              gamma_valid,
    output logic              sel_init,
    output logic              acs_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done,
    input  logic              done_ack
);

    localparam int PH_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(STEP_CYC - 1);
    localparam logic [ADDR_W-1:0] STEP_LAST = ADDR_W'(FRAME_LEN - 1);

    // Reject parameter sets the controller cannot sequence correctly.
    if (N < 1 || STEP_CYC < 1 || FRAME_LEN < 1 || FRAME_LEN > (1 << ADDR_W)) begin : g_bad_params
        $error("alpha_seq_ctrl: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic [PH_W-1:0]   phase_q, phase_d;

    // Registered output images, computed from the next state.
    logic              frm_ready_q;
    logic              sel_init_q;
    logic              acs_q;
    logic              wr_slot_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] wr_addr_q;

    logic              gamma_ok;
    logic              step_en;
    logic              wr_fire;
    logic              wr_slot_d;

`ifdef ALPHA_SEQ_STALL_EN
    assign gamma_ok = gamma_valid;
`else
    logic unused_gamma;
    assign unused_gamma = gamma_valid;
    assign gamma_ok     = 1'b1;
`endif

    assign step_en = (state_q == S_RUN) && gamma_ok;
    assign wr_fire = step_en && (phase_q == PH_LAST);

    // Next-state and step/phase counter logic.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        phase_d = phase_q;
        unique case (state_q)
            S_IDLE: begin
                if (frm_valid) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                state_d = S_RUN;
                step_d  = '0;
                phase_d = '0;
            end
            S_RUN: begin
                if (step_en) begin
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        if (step_q == STEP_LAST) begin
                            // Step index parks on the last address; no wrap.
                            state_d = S_DONE;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (done_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign wr_slot_d = (state_d == S_RUN) && (phase_d == PH_LAST);

    // State, counters and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            phase_q     <= '0;
            frm_ready_q <= 1'b1;
            sel_init_q  <= 1'b0;
            acs_q       <= 1'b0;
            wr_slot_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            phase_q     <= phase_d;
            frm_ready_q <= (state_d == S_IDLE);
            sel_init_q  <= (state_d == S_INIT);
            acs_q       <= (state_d == S_INIT) || (state_d == S_RUN);
            wr_slot_q   <= wr_slot_d;
            busy_q      <= (state_d == S_INIT) || (state_d == S_RUN);
            done_q      <= (state_d == S_DONE);
`ifdef ALPHA_SEQ_STALL_EN
            // Address register only records writes that actually happen.
            if (wr_fire) begin
                wr_addr_q <= step_q;
            end
`else
            // Address is loaded on entry to the write cycle of each step.
            if (wr_slot_d) begin
                wr_addr_q <= step_d;
            end
`endif
        end
    end

    assign frm_ready = frm_ready_q;
    assign sel_init  = sel_init_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef ALPHA_SEQ_STALL_EN
    // INIT never stalls; RUN cycles are gated by gamma_valid in-cycle, and a
    // stalled write slot keeps showing the previous write address.
    assign acs_en  = acs_q && (sel_init_q || gamma_valid);
    assign wr_en   = wr_fire;
    assign wr_addr = wr_fire ? step_q : wr_addr_q;
`else
    logic unused_wr_fire;
    assign unused_wr_fire = wr_fire;
    assign acs_en  = acs_q;
    assign wr_en   = wr_slot_q;
    assign wr_addr = wr_addr_q;
`endif

endmodule

// File: tb/tb_alpha_seq_ctrl.sv
// tb_alpha_seq_ctrl: directed bench for alpha_seq_ctrl at FRAME_LEN=14,
// STEP_CYC=2. Cycle 1 is the cycle after the handshake edge.
module tb_alpha_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       frm_valid;
    logic       frm_ready;
    logic       gamma_valid;
    logic       sel_init;
    logic       acs_en;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic       busy;
    logic       done;
    logic       done_ack;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [3:0]  exp_addr = '0;

    always #5 clk = ~clk;

    alpha_seq_ctrl #(
        .N(12),
        .FRAME_LEN(14),
        .ADDR_W(4),
        .STEP_CYC(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frm_valid(frm_valid),
        .frm_ready(frm_ready),
        .gamma_valid(gamma_valid),
        .sel_init(sel_init),
        .acs_en(acs_en),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .busy(busy),
        .done(done),
        .done_ack(done_ack)
    );

    // Output vector: {frm_ready, sel_init, acs_en, wr_en, busy, done, wr_addr}
    function automatic logic [9:0] obs();
        return {frm_ready, sel_init, acs_en, wr_en, busy, done, wr_addr};
    endfunction

    function automatic logic [9:0] idle_exp(input logic [3:0] held);
        return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, held};
    endfunction

    // Hand-derived nominal timing: INIT c1, writes on odd cycles 3..29
    // carrying addresses 0..13, done from c30, busy/acs_en in c1..c29.
    function automatic logic [9:0] nominal_exp(input int c, input logic [3:0] held);
        logic       sel, act, wr, dn;
        logic [3:0] a;
        sel = (c == 1);
        act = (c >= 1) && (c <= 29);
        wr  = (c >= 3) && (c <= 29) && (c % 2 == 1);
        dn  = (c >= 30);
        a   = wr ? 4'((c - 3) / 2) : held;
        return {1'b0, sel, act, wr, act, dn, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        #1;
        check("reset_during", 32'(obs()), 32'(idle_exp(4'd0)));
        rst = 1'b0;
        tick();
        #1;
        check("reset_after", 32'(obs()), 32'(idle_exp(4'd0)));
        exp_addr = '0;
    endtask

    // Entered in an IDLE cycle; runs handshake, frame, 10+ hold cycles, ack.
    task automatic run_frame(input string name, input bit spur, input bit gam_gap);
        logic [9:0] e;
        frm_valid = 1'b1;
        tick();
        if (!spur) frm_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            done_ack    = spur && (c == 10 || c == 20);
            gamma_valid = !(gam_gap && c >= 4 && c <= 6);
            #1;
            e = nominal_exp(c, exp_addr);
            check($sformatf("%s_c%0d", name, c), 32'(obs()), 32'(e));
            exp_addr = e[3:0];
            tick();
        end
        done_ack    = 1'b0;
        gamma_valid = 1'b1;
        #1;
        check($sformatf("%s_hold_end", name), 32'(obs()), 32'(nominal_exp(41, exp_addr)));
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        #1;
        check($sformatf("%s_ack_idle", name), 32'(obs()), 32'(idle_exp(exp_addr)));
    endtask

    task automatic mid_reset();
        logic [9:0] e;
        frm_valid = 1'b1;
        tick();
        frm_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            #1;
            e = nominal_exp(c, exp_addr);
            check($sformatf("mrst_c%0d", c), 32'(obs()), 32'(e));
            exp_addr = e[3:0];
            if (c == 12) rst = 1'b1;
            tick();
        end
        rst      = 1'b0;
        exp_addr = '0;
        for (int c = 13; c <= 16; c++) begin
            #1;
            check($sformatf("mrst_idle_c%0d", c), 32'(obs()), 32'(idle_exp(4'd0)));
            tick();
        end
    endtask

`ifdef ALPHA_SEQ_STALL_EN
    // gamma_valid low in c1 (INIT must not stall) and c4..c6 (RUN stalls).
    task automatic stall_frame();
        logic [9:0] e;
        frm_valid = 1'b1;
        tick();
        frm_valid = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            gamma_valid = !((c >= 4 && c <= 6) || c == 1);
            #1;
            if (c >= 4 && c <= 6)
                e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exp_addr};
            else
                e = nominal_exp((c <= 3) ? c : c - 3, exp_addr);
            check($sformatf("stall_c%0d", c), 32'(obs()), 32'(e));
            exp_addr = e[3:0];
            tick();
        end
        gamma_valid = 1'b1;
        done_ack    = 1'b1;
        tick();
        done_ack = 1'b0;
        #1;
        check("stall_ack_idle", 32'(obs()), 32'(idle_exp(exp_addr)));
    endtask
`endif

    initial begin
        rst         = 1'b1;
        frm_valid   = 1'b0;
        gamma_valid = 1'b1;
        done_ack    = 1'b0;

        do_reset();

        // Idle with done_ack pulsed: must be ignored.
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        #1;
        check("idle_ack_ignored", 32'(obs()), 32'(idle_exp(4'd0)));

        run_frame("nom", 1'b0, 1'b0);
`ifndef ALPHA_SEQ_STALL_EN
        run_frame("gamma_ignored", 1'b0, 1'b1);
`endif
        mid_reset();
        run_frame("after_rst", 1'b0, 1'b0);

        // frm_valid held high through two frames, done_ack pulsed in RUN.
        run_frame("spur_a", 1'b1, 1'b0);
        run_frame("spur_b", 1'b1, 1'b0);
        frm_valid = 1'b0;
        tick();
        #1;
        check("spur_end_idle", 32'(obs()), 32'(idle_exp(exp_addr)));

`ifdef ALPHA_SEQ_STALL_EN
        stall_frame();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alpha_seq_ctrl.md
ALPHA_SEQ_CTRL -- requirements
Module: alpha_seq_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 12, giving the state-metric width (pass-through sizing only).
REQ-002 The block SHALL have parameter FRAME_LEN, default 14, giving the trellis steps per frame.
REQ-003 The block SHALL have parameter ADDR_W, default 4, giving the metric-memory address width; FRAME_LEN SHALL be <= 2^ADDR_W.
REQ-004 The block SHALL have parameter STEP_CYC, default 2, giving the cycles per ACS recursion step (the datapath loop depth); legal values are >= 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port frm_valid, input, 1 bit: the upstream requests a new frame.
REQ-008 The block SHALL have port frm_ready, output, 1 bit: the controller can accept a frame.
REQ-009 The block SHALL have port gamma_valid, input, 1 bit: branch metrics for the current step are available (used only under ALPHA_SEQ_STALL_EN).
REQ-010 The block SHALL have port sel_init, output, 1 bit: the datapath mux selects external initial metrics (1) or fed-back metrics (0).
REQ-011 The block SHALL have port acs_en, output, 1 bit: the datapath add/compare registers advance.
REQ-012 The block SHALL have port wr_en, output, 1 bit: write the comparator outputs to metric memory.
REQ-013 The block SHALL have port wr_addr, output, ADDR_W bits: the metric-memory write address, equal to the step index.
REQ-014 The block SHALL have port busy, output, 1 bit: high in INIT and RUN.
REQ-015 The block SHALL have port done, output, 1 bit: the frame's metrics are complete and held until acknowledged.
REQ-016 The block SHALL have port done_ack, input, 1 bit: the downstream has consumed the frame.

Function
REQ-017 The controller SHALL implement the states IDLE, INIT, RUN and DONE.
REQ-018 In IDLE, frm_ready SHALL be 1; when frm_valid=1 and frm_ready=1 at an edge, the next state SHALL be INIT; no other state SHALL assert frm_ready.
REQ-019 INIT SHALL last exactly 1 cycle with sel_init=1, acs_en=1 and wr_en=0, and SHALL then enter RUN with step_cnt=0 and phase_cnt=0.
REQ-020 In RUN, sel_init SHALL be 0; each step SHALL occupy STEP_CYC enabled cycles counted by phase_cnt (0..STEP_CYC-1), and acs_en SHALL be 1 on every enabled cycle.
REQ-021 wr_en SHALL be 1 only on the enabled cycle where phase_cnt=STEP_CYC-1, with wr_addr=step_cnt; phase_cnt SHALL then wrap to 0 and step_cnt SHALL increment.
REQ-022 After the write with step_cnt=FRAME_LEN-1, the state SHALL become DONE; step_cnt SHALL never exceed FRAME_LEN-1, and wr_addr SHALL not wrap within a frame.
REQ-023 In DONE, done SHALL be 1 and acs_en, wr_en and busy SHALL be 0; done_ack=1 SHALL return the state to IDLE on the next edge.
REQ-024 done_ack outside DONE, and frm_valid outside IDLE, SHALL be ignored.
REQ-025 wr_addr SHALL hold its last value when wr_en=0.
REQ-026 The done to frm_ready turnaround SHALL be 1 cycle: done_ack sampled at edge E gives IDLE and frm_ready=1 from E.

Reset
REQ-027 When rst=1 at an edge, the block SHALL enter IDLE and clear step_cnt, phase_cnt and wr_addr to 0; rst has priority over all other inputs.
REQ-028 During and after reset, the outputs SHALL be frm_ready=1, sel_init=0, acs_en=0, wr_en=0, busy=0 and done=0.
REQ-029 A reset asserted mid-frame SHALL abort the frame with no further wr_en pulses; a fresh frm_valid handshake SHALL be required to restart.

Configuration
REQ-030 With macro ALPHA_SEQ_STALL_EN defined, an enabled RUN cycle SHALL require gamma_valid=1; when gamma_valid=0, phase_cnt and step_cnt SHALL hold, and acs_en and wr_en SHALL be 0. INIT SHALL not stall.
REQ-031 With ALPHA_SEQ_STALL_EN undefined, gamma_valid SHALL be ignored and every RUN cycle SHALL be enabled.

Verification (FRAME_LEN=14, STEP_CYC=2, handshake at edge 0)
REQ-032 Nominal frame, macro off: INIT in cycle 1; wr_en in cycles 3,5,...,29 with wr_addr 0..13; done=1 from cycle 30; busy=1 in cycles 1-29 only.
REQ-033 Done hold: done_ack held low 10 cycles after done rises -> done stays 1, no wr_en, frm_ready=0; done_ack=1 -> IDLE and frm_ready=1 on the next cycle.
REQ-034 Stall, macro on: gamma_valid=0 in cycles 4-6 -> acs_en=0 and wr_en=0 in those cycles; the write for wr_addr=0 at cycle 3 is unaffected; the write for wr_addr=1 moves from cycle 5 to 8; done rises at cycle 33.
REQ-035 Reset mid-frame: rst=1 at cycle 12 -> from cycle 13, busy=0, frm_ready=1, wr_addr=0, no wr_en; a new handshake gives a full 14-write frame.
REQ-036 Spurious inputs: frm_valid held high through RUN, and done_ack pulsed during RUN -> frame timing is identical to REQ-032; back-to-back frames start only after done_ack.
